// File: rtl/rose_expect_pkg.sv
// Shared types and helpers for the rose/expect handshake sequencer.
package rose_expect_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ROSE = 2'd1,
      WAIT_CHK  = 2'd2,
      DONE      = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_PASS = 2'd1,
      RES_FAIL = 2'd2
   } result_e;

   localparam int unsigned SAT_W = 64;

   // Increment that sticks at the all-ones value of a width-bit field.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input int unsigned    width);
      logic [SAT_W-1:0] top;
      top = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
      return (val >= top) ? val : val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/rose_delay_line.sv
// Rise detector plus the DELAY-deep pending-attempt shift register;
// each entry carries a tag marking the single-shot attempt.
module rose_delay_line #(
   parameter int DELAY = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_i,
   input  logic allow_i,
   input  logic clr_i,
   input  logic tag_i,
   input  logic tag_kill_i,
   output logic launch_o,
   output logic chk_vld_o,
   output logic chk_tag_o,
   output logic pend_any_o
);

   logic             a_q, a_d;
   logic [DELAY:1]   pend_q, pend_d;
   logic [DELAY:1]   tag_q, tag_d;

   assign launch_o   = a_i & ~a_q & allow_i & ~clr_i;
   assign chk_vld_o  = pend_q[DELAY];
   assign chk_tag_o  = tag_q[DELAY];
   assign pend_any_o = |pend_q;

   always_comb begin
      a_d    = a_i;
      pend_d = '0;
      tag_d  = '0;
      if (!clr_i) begin
         pend_d[1] = launch_o;
         tag_d[1]  = launch_o & tag_i;
         for (int i = 2; i <= DELAY; i++) begin
            pend_d[i] = pend_q[i-1];
            tag_d[i]  = tag_q[i-1] & ~tag_kill_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= 1'b0;
         pend_q <= '0;
         tag_q  <= '0;
      end else begin
         a_q    <= a_d;
         pend_q <= pend_d;
         tag_q  <= tag_d;
      end
   end

endmodule

// File: rtl/rose_expect_ctrl.sv
// Sequencer/checker for "$rose(a) |-> ##DELAY b": launches attempts, reports
// results, keeps saturating statistics and runs the single-shot FSM.
module rose_expect_ctrl
   import rose_expect_pkg::*;
#(
   parameter int DELAY = 10,
   parameter int CNT_W = 16,
   parameter int TS_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             cont,
   input  logic             arm,
   input  logic             a_i,
   input  logic             b_i,
   output logic             attempt_o,
   output logic             pass_o,
   output logic             fail_o,
   output logic             done_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o,
   output logic             fail_seen_o,
   output logic [TS_W-1:0]  first_fail_ts_o
);

   state_e           state_q, state_d;
   result_e          res_q, res_d;
   logic             res_tag_q, res_tag_d;
   logic             attempt_q, attempt_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             fail_seen_q, fail_seen_d;
   logic [TS_W-1:0]  first_ts_q, first_ts_d;
   logic [TS_W-1:0]  ts_q, ts_d;

   logic launch, chk_vld, chk_tag, pend_any;
   logic allow, tag_req;

   assign allow   = en & (cont | (state_q == WAIT_ROSE));
   assign tag_req = ~cont & (state_q == WAIT_ROSE);

   rose_delay_line #(.DELAY(DELAY)) u_dl (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_i        (a_i),
      .allow_i    (allow),
      .clr_i      (clr),
      .tag_i      (tag_req),
      .tag_kill_i (cont),
      .launch_o   (launch),
      .chk_vld_o  (chk_vld),
      .chk_tag_o  (chk_tag),
      .pend_any_o (pend_any)
   );

   always_comb begin
      ts_d        = ts_q + TS_W'(1);
      attempt_d   = launch;
      res_d       = RES_NONE;
      res_tag_d   = 1'b0;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      fail_seen_d = fail_seen_q;
      first_ts_d  = first_ts_q;
      state_d     = state_q;
      if (clr) begin
         pass_cnt_d  = '0;
         fail_cnt_d  = '0;
         fail_seen_d = 1'b0;
         first_ts_d  = '0;
         state_d     = IDLE;
      end else begin
         if (chk_vld) begin
            res_tag_d = chk_tag;
            if (b_i) begin
               res_d      = RES_PASS;
               pass_cnt_d = CNT_W'(sat_inc(SAT_W'(pass_cnt_q), CNT_W));
            end else begin
               res_d      = RES_FAIL;
               fail_cnt_d = CNT_W'(sat_inc(SAT_W'(fail_cnt_q), CNT_W));
               if (!fail_seen_q) begin
                  fail_seen_d = 1'b1;
                  first_ts_d  = ts_q;
               end
            end
         end
         // The single-shot attempt is considered resolved once its result pulse is visible.
         if (cont) begin
            state_d = IDLE;
         end else begin
            unique case (state_q)
               IDLE:      if (arm)    state_d = WAIT_ROSE;
               WAIT_ROSE: if (launch) state_d = WAIT_CHK;
               WAIT_CHK:  if (res_tag_q && (res_q != RES_NONE)) state_d = DONE;
               DONE:      state_d = IDLE;
               default:   state_d = IDLE;
            endcase
         end
      end
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         res_q       <= RES_NONE;
         res_tag_q   <= 1'b0;
         attempt_q   <= 1'b0;
         done_q      <= 1'b0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         fail_seen_q <= 1'b0;
         first_ts_q  <= '0;
         ts_q        <= '0;
      end else begin
         state_q     <= state_d;
         res_q       <= res_d;
         res_tag_q   <= res_tag_d;
         attempt_q   <= attempt_d;
         done_q      <= done_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_seen_q <= fail_seen_d;
         first_ts_q  <= first_ts_d;
         ts_q        <= ts_d;
      end
   end

   assign attempt_o       = attempt_q;
   assign pass_o          = (res_q == RES_PASS);
   assign fail_o          = (res_q == RES_FAIL);
   assign done_o          = done_q;
   assign busy_o          = (state_q != IDLE) | pend_any;
   assign pass_cnt_o      = pass_cnt_q;
   assign fail_cnt_o      = fail_cnt_q;
   assign fail_seen_o     = fail_seen_q;
   assign first_fail_ts_o = first_ts_q;

endmodule

// File: tb/tb_rose_expect_ctrl.sv
// Directed and randomized bench for rose_expect_ctrl against an
// attempt-queue reference model.
module tb_rose_expect_ctrl;

   localparam int DELAY = 10;
   localparam int CNT_W = 2;
   localparam int TS_W  = 32;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam int PH_IDLE     = 0;
   localparam int PH_ARMED    = 1;
   localparam int PH_INFLIGHT = 2;
   localparam int PH_DONE     = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0, clr = 1'b0, cont = 1'b1, arm = 1'b0, a_i = 1'b0, b_i = 1'b0;
   logic             attempt_o, pass_o, fail_o, done_o, busy_o, fail_seen_o;
   logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o;
   logic [TS_W-1:0]  first_fail_ts_o;

   int checks = 0;
   int errors = 0;

   rose_expect_ctrl #(.DELAY(DELAY), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .en              (en),
      .clr             (clr),
      .cont            (cont),
      .arm             (arm),
      .a_i             (a_i),
      .b_i             (b_i),
      .attempt_o       (attempt_o),
      .pass_o          (pass_o),
      .fail_o          (fail_o),
      .done_o          (done_o),
      .busy_o          (busy_o),
      .pass_cnt_o      (pass_cnt_o),
      .fail_cnt_o      (fail_cnt_o),
      .fail_seen_o     (fail_seen_o),
      .first_fail_ts_o (first_fail_ts_o)
   );

   always #5 clk = ~clk;

   // Reference model: outstanding attempts are a queue of due edges.
   typedef struct {int due; bit tag;} ent_t;
   ent_t q[$];
   int   m_n, m_pc, m_fc, m_fts, m_ph;
   bit   m_prev_a, m_seen, m_prev_res_tag;
   bit   e_attempt, e_pass, e_fail, e_done, e_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_n = 0; m_pc = 0; m_fc = 0; m_fts = 0; m_ph = PH_IDLE;
      m_prev_a = 0; m_seen = 0; m_prev_res_tag = 0;
      e_attempt = 0; e_pass = 0; e_fail = 0; e_done = 0; e_busy = 0;
   endfunction

   function automatic void model_edge(bit a, bit b, bit e, bit c, bit ct, bit ar);
      bit rose, launch, new_tag, res_tag;
      rose     = a && !m_prev_a;
      m_prev_a = a;
      launch   = rose && e && !c && (ct || m_ph == PH_ARMED);
      new_tag  = launch && !ct && m_ph == PH_ARMED;
      res_tag  = 0; e_pass = 0; e_fail = 0;
      if (c) begin
         q.delete();
         m_pc = 0; m_fc = 0; m_seen = 0; m_fts = 0;
      end else begin
         if (q.size() > 0 && q[0].due == m_n) begin
            res_tag = q[0].tag;
            if (b) begin
               e_pass = 1;
               if (m_pc < CMAX) m_pc++;
            end else begin
               e_fail = 1;
               if (m_fc < CMAX) m_fc++;
               if (!m_seen) begin m_seen = 1; m_fts = m_n; end
            end
            void'(q.pop_front());
         end
         if (ct) foreach (q[i]) q[i].tag = 0;
         if (launch) q.push_back('{due: m_n + DELAY, tag: new_tag});
      end
      if (c || ct) m_ph = PH_IDLE;
      else if (m_ph == PH_IDLE && ar) m_ph = PH_ARMED;
      else if (m_ph == PH_ARMED && launch) m_ph = PH_INFLIGHT;
      else if (m_ph == PH_INFLIGHT && m_prev_res_tag) m_ph = PH_DONE;
      else if (m_ph == PH_DONE) m_ph = PH_IDLE;
      m_prev_res_tag = res_tag;
      e_attempt = launch;
      e_done    = (m_ph == PH_DONE);
      e_busy    = (m_ph != PH_IDLE) || (q.size() > 0);
      m_n++;
   endfunction

   task automatic check_model();
      chk("attempt",   attempt_o,       e_attempt);
      chk("pass",      pass_o,          e_pass);
      chk("fail",      fail_o,          e_fail);
      chk("done",      done_o,          e_done);
      chk("busy",      busy_o,          e_busy);
      chk("pass_cnt",  pass_cnt_o,      m_pc);
      chk("fail_cnt",  fail_cnt_o,      m_fc);
      chk("fail_seen", fail_seen_o,     m_seen);
      chk("first_ts",  first_fail_ts_o, m_fts);
   endtask

   task automatic check_zero(input string tag);
      logic [63:0] all;
      all = {attempt_o, pass_o, fail_o, done_o, busy_o, fail_seen_o};
      chk({tag, "_flags"}, all, 0);
      chk({tag, "_pass_cnt"}, pass_cnt_o, 0);
      chk({tag, "_fail_cnt"}, fail_cnt_o, 0);
      chk({tag, "_first_ts"}, first_fail_ts_o, 0);
   endtask

   task automatic step(input bit a, b, e, c, ct, ar);
      a_i = a; b_i = b; en = e; clr = c; cont = ct; arm = ar;
      @(posedge clk);
      model_edge(a, b, e, c, ct, ar);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      a_i = 0; b_i = 0; en = 0; clr = 0; cont = 1; arm = 0;
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      do_reset();

      // Single pass: rise at edge 5, b high at edge 15.
      for (int e = 0; e < 18; e++) begin
         step(e == 5, e == 15, 1, 0, 1, 0);
         if (e == 5)  chk("pass_attempt", attempt_o, 1);
         if (e == 15) begin
            chk("pass_pulse", pass_o, 1);
            chk("pass_cnt1", pass_cnt_o, 1);
            chk("pass_fcnt0", fail_cnt_o, 0);
         end
      end

      // Failures: first at edge 15 records its timestamp, second at edge 40 does not.
      do_reset();
      for (int e = 0; e < 43; e++) begin
         step(e == 5 || e == 30, !(e == 15 || e == 40), 1, 0, 1, 0);
         if (e == 15) begin
            chk("fail_pulse", fail_o, 1);
            chk("fail_seen", fail_seen_o, 1);
            chk("fail_ts15", first_fail_ts_o, 15);
         end
         if (e == 40) begin
            chk("fail2_cnt", fail_cnt_o, 2);
            chk("fail2_ts", first_fail_ts_o, 15);
         end
      end

      // Overlapping attempts launched at edges 2, 4 and 6.
      do_reset();
      for (int e = 0; e < 20; e++) begin
         step(e == 2 || e == 4 || e == 6, e == 12 || e == 16, 1, 0, 1, 0);
         if (e == 14) chk("ovl_fail", fail_o, 1);
      end
      chk("ovl_pcnt", pass_cnt_o, 2);
      chk("ovl_fcnt", fail_cnt_o, 1);

      // Single-shot: armed at 3, rises at 8 and 10, only the first is checked.
      do_reset();
      for (int e = 0; e < 24; e++) begin
         step(e == 8 || e == 10, e == 18, 1, 0, 0, e == 3);
         if (e == 10) chk("ss_ignored", attempt_o, 0);
         if (e == 18) chk("ss_pass", pass_o, 1);
         if (e == 19) chk("ss_done", done_o, 1);
         if (e == 20) chk("ss_idle", busy_o, 0);
      end

      // Saturation of the pass counter, then a clear on a pending check edge.
      do_reset();
      for (int e = 0; e < 40; e++) begin
         step(e == 2 || e == 4 || e == 6 || e == 8 || e == 10 || e == 25, 1, 1, e == 35, 1, 0);
         if (e == 20) chk("sat_pcnt", pass_cnt_o, CMAX);
         if (e == 35) begin
            chk("clr_nopulse", pass_o, 0);
            chk("clr_pcnt", pass_cnt_o, 0);
         end
      end

      // Asynchronous reset while the single-shot attempt is in flight.
      do_reset();
      for (int e = 0; e < 8; e++) step(e == 3, 1, 1, 0, 0, e == 1);
      chk("ar_busy_before", busy_o, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async");
      chk("async_busy", busy_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int e = 0; e < DELAY + 4; e++) step(0, 1, 1, 0, 0, 0);

      // Randomized blocks mixing modes, enables, arms and rare clears.
      do_reset();
      for (int blk = 0; blk < 12; blk++) begin
         bit ct;
         ct = bit'($urandom_range(0, 1));
         for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 29) == 0) ct = !ct;
            step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0,
                 ct, $urandom_range(0, 5) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rose_expect_ctrl.md
Name: rose_expect_ctrl

Overview:
- Synthesizable sequencer/checker for the `$rose(a) |-> ##DELAY b` handshake between a request line `a_i` and its delayed response `b_i`.
- Launches one check attempt per rising edge of `a_i` and tracks every outstanding attempt.
- Reports a pass or fail pulse for each attempt, keeps saturating statistics, and captures the time of the first failure.
- Offers a blocking single-shot mode (arm, first attempt, done) alongside a continuous mode.
- Sits beside the request/response datapath as its on-chip protocol sequencer and monitor.

Parameters:
- DELAY, 10, cycles from the sampled rise of `a_i` to the sampled check of `b_i`; legal range ≥1.
- CNT_W, 16, width of the pass and fail counters.
- TS_W, 32, width of the free-running cycle timestamp.

Ports:
- clk  in  1  sampling clock; all state is updated on its posedge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  1 = new attempts may launch; 0 = no launches, pending attempts still resolve.
- clr  in  1  synchronous clear of all state except the timestamp.
- cont  in  1  1 = continuous mode; 0 = single-shot mode.
- arm  in  1  single-shot start pulse, honoured only in IDLE.
- a_i  in  1  request line.
- b_i  in  1  response line.
- attempt_o  out  1  pulse: an attempt launched on this edge.
- pass_o  out  1  pulse: one attempt passed.
- fail_o  out  1  pulse: one attempt failed.
- done_o  out  1  pulse: single-shot sequence complete.
- busy_o  out  1  single-shot FSM is not in IDLE, or any attempt is pending.
- pass_cnt_o  out  CNT_W  saturating count of passes.
- fail_cnt_o  out  CNT_W  saturating count of failures.
- fail_seen_o  out  1  sticky flag: at least one failure.
- first_fail_ts_o  out  TS_W  timestamp of the first failing check.

Behaviour:
- Reset (rst_n=0, asynchronous): every output is 0.
  - a_q=0, pend=0, FSM=IDLE, timestamp=0.
- Rise detect: `rose = a_i & ~a_q`.
  - a_q samples a_i every cycle, regardless of en or clr.
  - a_i high on the first edge after reset counts as a rise.
- Launch condition: `launch = rose & en & ~clr & (cont | state==WAIT_ROSE)`.
  - attempt_o is registered; it is high in the cycle after the launch edge.
- Delay line: shift register `pend[1..DELAY]`.
  - A launch on edge k sets pend[1] at edge k. Entries shift by one each edge.
  - The attempt is checked against b_i sampled at edge k+DELAY.
  - Multiple outstanding attempts are tracked independently; a new rise can only occur every ≥2 cycles.
- Check result: b_i=1 gives pass, b_i=0 gives fail.
  - pass_o / fail_o are registered; they assert in the cycle after edge k+DELAY.
  - At most one result per edge.
- Counters:
  - Increment on the result edge and saturate at all-ones; there is no wrap.
  - fail_seen_o is sticky until clr.
  - first_fail_ts_o is loaded with the timestamp at the check edge of the first failure only.
- Timestamp: free-running TS_W counter that wraps modulo 2^TS_W. clr does not reset it.
- Single-shot FSM (active when cont=0):
  - IDLE → WAIT_ROSE on arm.
  - WAIT_ROSE → WAIT_CHK on launch.
  - WAIT_CHK → DONE when that attempt resolves.
  - DONE → IDLE after one cycle; done_o is high exactly during DONE.
  - Rises in WAIT_CHK or DONE are ignored.
  - arm outside IDLE is ignored.
  - In WAIT_ROSE with en=0, the FSM waits indefinitely.
- cont=1: the FSM is held in IDLE and done_o never asserts.
- cont changed while attempts are pending: those attempts still resolve and are counted. The FSM returns to IDLE when cont=1.
- clr: highest priority after reset.
  - Zeroes pend, counters, fail_seen_o and first_fail_ts_o; FSM → IDLE.
  - Suppresses any launch or result on the same edge.
- Reset mid-operation: all pending attempts are dropped and no result pulses are emitted.

Decomposition:
- Package rose_expect_pkg holds:
  - the state enum (IDLE, WAIT_ROSE, WAIT_CHK, DONE);
  - the result enum (RES_NONE, RES_PASS, RES_FAIL);
  - a saturating-increment function parameterised by width.
- Sub-module rose_delay_line: rise detect plus the DELAY-deep pending shift register.
  - Outputs: launch-valid and check-valid, plus a tag bit marking the single-shot attempt.
- The top level holds the FSM, counters and timestamp.

Test Plan:
- Pass: cont=1, en=1, a_i rises at edge 5, b_i=1 at edge 15 → attempt_o in cycle 6, pass_o in cycle 16; pass_cnt=1, fail_cnt=0.
- Fail: a_i rises at edge 5, b_i=0 at edge 15 (high at 14 and 16) → fail_o in cycle 16, fail_seen_o=1, first_fail_ts_o=15; a second fail at edge 40 leaves ts=15.
- Overlap: a_i toggles, rising at edges 2, 4 and 6; b_i high at 12 and 16, low at 14 → results pass, fail, pass; pass_cnt=2, fail_cnt=1.
- Single-shot: cont=0, arm at edge 3, rises at edges 8 and 10, b_i=1 at 18 → one attempt only; pass_o in cycle 19, done_o in cycle 20, busy_o low from cycle 21.
- Saturation/clear: CNT_W=2 with 5 passes → pass_cnt=3; clr at the edge of a pending check → no result pulse and counters=0.
- Async reset: rst_n low mid-WAIT_CHK → all outputs 0 immediately; no result pulse after release.
